// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle between the two MIPS requesters (IF fetch, DM load/store), the
// shared arbiter and the single-port synchronous memory behind it.
interface mips_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Core / memory side
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Two-requester arbiter (IF fetch / DM load-store) in front of a fixed-latency
// single-port memory, with bounded IF starvation. Optional ARB_PERF_CNT_EN adds perf_conflicts.
module mips_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_mem_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]         perf_conflicts
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_DM} state_t;

    localparam logic [3:0] LAT_RELOAD = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            r_state;
    logic [3:0]        r_lat_cnt;
    logic [3:0]        r_starve_cnt;
    logic              r_dm_store;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic w_idle;
    logic w_grant_if;
    logic w_grant_dm;
    logic w_if_done;
    logic w_dm_done;

    assign w_idle    = (r_state == IDLE);
    assign w_if_done = (r_state == WAIT_IF) && (r_lat_cnt == 4'd0);
    assign w_dm_done = (r_state == WAIT_DM) && (r_lat_cnt == 4'd0);

    // Grant is combinational so the access is strobed in the arbitration cycle;
    // rst_n gates it so nothing is granted while reset is held.
    always_comb begin
        w_grant_if = 1'b0;
        w_grant_dm = 1'b0;
        if (rst_n && w_idle) begin
            if (bus.if_req && (!bus.dm_req || (r_starve_cnt == STARVE_LIM)))
                w_grant_if = 1'b1;
            else if (bus.dm_req)
                w_grant_dm = 1'b1;
        end
    end

    assign bus.if_gnt    = w_grant_if;
    assign bus.dm_gnt    = w_grant_dm;
    assign bus.mem_en    = w_grant_if | w_grant_dm;
    assign bus.mem_we    = w_grant_dm & bus.dm_we;
    assign bus.mem_addr  = w_grant_if ? bus.if_addr :
                           w_grant_dm ? bus.dm_addr : {ADDR_W{1'b0}};
    assign bus.mem_wdata = (w_grant_dm & bus.dm_we) ? bus.dm_wdata : {DATA_W{1'b0}};
    assign bus.busy      = ~w_idle;

    // Read data is passed through during the completion pulse and held afterwards.
    assign bus.if_rvalid = w_if_done;
    assign bus.dm_rvalid = w_dm_done;
    assign bus.if_rdata  = w_if_done ? bus.mem_rdata : r_if_rdata;
    assign bus.dm_rdata  = w_dm_done ? (r_dm_store ? {DATA_W{1'b0}} : bus.mem_rdata)
                                     : r_dm_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_lat_cnt    <= 4'd0;
            r_starve_cnt <= 4'd0;
            r_dm_store   <= 1'b0;
            r_if_rdata   <= {DATA_W{1'b0}};
            r_dm_rdata   <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_if) begin
                        r_state      <= WAIT_IF;
                        r_lat_cnt    <= LAT_RELOAD;
                        r_starve_cnt <= 4'd0;
                    end else if (w_grant_dm) begin
                        r_state    <= WAIT_DM;
                        r_lat_cnt  <= LAT_RELOAD;
                        r_dm_store <= bus.dm_we;
                        if (bus.if_req && (r_starve_cnt != STARVE_LIM))
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                end
                WAIT_IF: begin
                    if (r_lat_cnt == 4'd0) begin
                        r_state    <= IDLE;
                        r_if_rdata <= bus.mem_rdata;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                WAIT_DM: begin
                    if (r_lat_cnt == 4'd0) begin
                        r_state    <= IDLE;
                        r_dm_rdata <= r_dm_store ? {DATA_W{1'b0}} : bus.mem_rdata;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [15:0] r_perf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_perf_cnt <= 16'd0;
        else if (w_idle && bus.if_req && bus.dm_req && (r_perf_cnt != 16'hFFFF))
            r_perf_cnt <= r_perf_cnt + 16'd1;
    end

    assign perf_conflicts = r_perf_cnt;
`endif
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: random IF/DM traffic against a
// cycle-level reference of the arbitration rules and a word-array memory model.
module tb_mips_mem_arbiter;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int LAT  = 3;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_conflicts;
`endif

    mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_conflicts (perf_conflicts)
`endif
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] init_val(input logic [AW-1:0] a);
        if (a == 10'd5) return 32'h2801000A;
        return ({22'h0, a} * 32'h9E3779B1) + 32'h12345677;
    endfunction

    // Physical memory: read data appears LAT cycles after the strobe.
    logic [31:0] dev_mem [1024];
    bit          dev_wr  [1024];
    logic [31:0] pipe    [LAT];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            pipe[0] <= dev_wr[bus.mem_addr] ? dev_mem[bus.mem_addr] : init_val(bus.mem_addr);
            if (bus.mem_we) begin
                dev_mem[bus.mem_addr] <= bus.mem_wdata;
                dev_wr[bus.mem_addr]  <= 1'b1;
            end
        end else begin
            pipe[0] <= 32'hA5A5A5A5;
        end
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    // Reference model state
    typedef struct { logic [31:0] data; int due; } rsp_t;
    rsp_t        ifq[$];
    rsp_t        dmq[$];
    logic [31:0] ref_mem [1024];
    bit          ref_wr  [1024];
    int          cyc = 0;
    int          busy_left = 0;
    int          starve = 0;
    logic [31:0] last_if = 0;
    logic [31:0] last_dm = 0;
    logic        prev_en = 0;
    int          if_gnt_cnt = 0;
    int          dm_gnt_cnt = 0;
    int          if_done = 0;
    int          dm_done = 0;
    int          perf_exp = 0;

    function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
        return ref_wr[a] ? ref_mem[a] : init_val(a);
    endfunction

    always @(negedge clk) begin
        logic free, e_if, e_dm, e_v;
        if (!rst_n) begin
            chk("rst_if_gnt", bus.if_gnt, 0);
            chk("rst_dm_gnt", bus.dm_gnt, 0);
            chk("rst_mem_en", bus.mem_en, 0);
            chk("rst_mem_we", bus.mem_we, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_if_rvalid", bus.if_rvalid, 0);
            chk("rst_dm_rvalid", bus.dm_rvalid, 0);
            chk("rst_if_rdata", bus.if_rdata, 0);
            chk("rst_dm_rdata", bus.dm_rdata, 0);
            chk("rst_mem_addr", 32'(bus.mem_addr), 0);
            chk("rst_mem_wdata", bus.mem_wdata, 0);
            ifq.delete();
            dmq.delete();
            busy_left = 0;
            starve = 0;
            last_if = 0;
            last_dm = 0;
            prev_en = 0;
            perf_exp = 0;
        end else begin
            free = (busy_left == 0);
            e_if = free && bus.if_req && (!bus.dm_req || starve == SMAX);
            e_dm = free && bus.dm_req && !e_if;
            chk("if_gnt", bus.if_gnt, e_if);
            chk("dm_gnt", bus.dm_gnt, e_dm);
            chk("mem_en", bus.mem_en, e_if | e_dm);
            chk("busy", bus.busy, !free);
            if (bus.mem_en && prev_en) chk("mem_en_b2b", 1, 0);
            prev_en = bus.mem_en;
`ifdef ARB_PERF_CNT_EN
            chk("perf_conflicts", 32'(perf_conflicts), perf_exp);
            if (free && bus.if_req && bus.dm_req && perf_exp != 16'hFFFF) perf_exp++;
`endif
            e_v = (ifq.size() > 0) && (ifq[0].due == cyc);
            chk("if_rvalid", bus.if_rvalid, e_v);
            if (e_v) begin
                chk("if_rdata", bus.if_rdata, ifq[0].data);
                last_if = ifq[0].data;
                void'(ifq.pop_front());
                if_done++;
            end else chk("if_rdata_hold", bus.if_rdata, last_if);
            e_v = (dmq.size() > 0) && (dmq[0].due == cyc);
            chk("dm_rvalid", bus.dm_rvalid, e_v);
            if (e_v) begin
                chk("dm_rdata", bus.dm_rdata, dmq[0].data);
                last_dm = dmq[0].data;
                void'(dmq.pop_front());
                dm_done++;
            end else chk("dm_rdata_hold", bus.dm_rdata, last_dm);

            if (e_if) begin
                chk("if_mem_addr", 32'(bus.mem_addr), 32'(bus.if_addr));
                chk("if_mem_we", bus.mem_we, 0);
                ifq.push_back('{ref_rd(bus.if_addr), cyc + LAT});
                starve = 0;
                busy_left = LAT;
            end else if (e_dm) begin
                chk("dm_mem_addr", 32'(bus.mem_addr), 32'(bus.dm_addr));
                chk("dm_mem_we", bus.mem_we, bus.dm_we);
                if (bus.dm_we) begin
                    chk("dm_mem_wdata", bus.mem_wdata, bus.dm_wdata);
                    dmq.push_back('{32'h0, cyc + LAT});
                    ref_mem[bus.dm_addr] = bus.dm_wdata;
                    ref_wr[bus.dm_addr]  = 1'b1;
                end else begin
                    dmq.push_back('{ref_rd(bus.dm_addr), cyc + LAT});
                end
                if (bus.if_req && starve < SMAX) starve++;
                busy_left = LAT;
            end else if (busy_left > 0) begin
                busy_left--;
            end
        end
        if (bus.if_gnt) if_gnt_cnt++;
        if (bus.dm_gnt) dm_gnt_cnt++;
        cyc++;
    end

    task automatic if_txn(input logic [AW-1:0] a, input int gap);
        int c0;
        int n;
        bus.if_addr = a;
        bus.if_req  = 1'b1;
        c0 = if_gnt_cnt;
        n  = 0;
        while (if_gnt_cnt == c0 && n < 400) begin @(posedge clk); n++; end
        #1;
        chk("if_gnt_timeout", 32'(if_gnt_cnt != c0), 1);
        bus.if_req = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic dm_txn(input logic we, input logic [AW-1:0] a, input logic [31:0] d, input int gap);
        int c0;
        int n;
        bus.dm_we    = we;
        bus.dm_addr  = a;
        bus.dm_wdata = d;
        bus.dm_req   = 1'b1;
        c0 = dm_gnt_cnt;
        n  = 0;
        while (dm_gnt_cnt == c0 && n < 400) begin @(posedge clk); n++; end
        #1;
        chk("dm_gnt_timeout", 32'(dm_gnt_cnt != c0), 1);
        bus.dm_req = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic settle();
        repeat (LAT + 4) @(posedge clk);
        #1;
    endtask

    initial begin
        int ic0;
        int dc0;
        bus.if_req = 0; bus.if_addr = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single fetch of the preloaded instruction word
        ic0 = if_done;
        if_txn(10'd5, 0);
        settle();
        chk("fetch5_done", 32'(if_done - ic0), 1);
        chk("fetch5_data", last_if, 32'h2801000A);

        // Store then load at word 20
        dm_txn(1'b1, 10'd20, 32'hDEADBEEF, 0);
        settle();
        chk("store20_rdata", last_dm, 32'h0);
        dm_txn(1'b0, 10'd20, 32'h0, 0);
        settle();
        chk("load20_rdata", last_dm, 32'hDEADBEEF);

        // Continuous contention: DM x4 then IF, repeating
        ic0 = if_gnt_cnt;
        dc0 = dm_gnt_cnt;
        fork
            for (int k = 0; k < 6; k++) if_txn(10'(40 + k), 0);
            for (int k = 0; k < 24; k++) dm_txn(1'b0, 10'(60 + k), 32'h0, 0);
        join
        settle();
        chk("contend_if_cnt", 32'(if_gnt_cnt - ic0), 6);
        chk("contend_dm_cnt", 32'(dm_gnt_cnt - dc0), 24);

        // Random mixed traffic over a small address window
        fork
            for (int k = 0; k < 80; k++)
                if_txn(10'($urandom_range(0, 31)), $urandom_range(0, 3));
            for (int k = 0; k < 80; k++)
                dm_txn(1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)), $urandom,
                       $urandom_range(0, 3));
        join
        settle();

        // Reset while a store sits in WAIT_DM with one cycle left
        dc0 = dm_done;
        bus.dm_we = 1'b1; bus.dm_addr = 10'd40; bus.dm_wdata = 32'hCAFEF00D;
        bus.dm_req = 1'b1;
        ic0 = dm_gnt_cnt;
        for (int n = 0; n < 400 && dm_gnt_cnt == ic0; n++) @(posedge clk);
        #1 bus.dm_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.if_addr = 10'd7;
        bus.if_req  = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        if_txn(10'd7, 0);
        settle();
        chk("rst_no_dm_rvalid", 32'(dm_done - dc0), 0);
        dm_txn(1'b0, 10'd40, 32'h0, 0);
        settle();
        chk("store_survives_rst", last_dm, 32'hCAFEF00D);

        repeat (5) @(posedge clk);
        #1;
        chk("ifq_drained", 32'(ifq.size()), 0);
        chk("dmq_drained", 32'(dmq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
